jt49_dcrm_sched: RTL and testbench

Time-multiplexed DC-removal scheduler for the three PSG channels. One shared first-order DC-removal datapath serves channels A, B and C in turn. Per-channel integrator and error state is held in a small register bank. Each sample strobe starts a fixed A→B→C sequence. The block sits between the channel volume stage (unsigned 8-bit) and the mixer, which takes signed 8-bit.

---
 rtl/jt49_dcrm_sched.sv | 114 +++++++++++
 tb/tb_jt49_dcrm_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jt49_dcrm_sched.sv
// Time-multiplexed DC-removal for PSG channels A/B/C: one shared first-order
// datapath walks A->B->C per sample strobe, with per-channel integrator/error state.
module jt49_dcrm_sched #(
    parameter int unsigned K = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic [7:0] din_a,
    input  logic [7:0] din_b,
    input  logic [7:0] din_c,
    output logic [7:0] dout_a,
    output logic [7:0] dout_b,
    output logic [7:0] dout_c,
    output logic       done,
    output logic       busy,
    output logic       overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_A    = 2'd1;
    localparam logic [1:0] ST_B    = 2'd2;
    localparam logic [1:0] ST_C    = 2'd3;

    logic [1:0]        r_state;
    logic [7:0]        r_x_a, r_x_b, r_x_c;
    logic signed [8:0] r_integ [0:2];
    logic signed [8:0] r_err   [0:2];

    logic [7:0]        w_x;
    logic signed [8:0] w_integ, w_err, w_exact, w_d2, w_step, w_integ_nx, w_err_nx;
    logic [7:0]        w_q, w_d;

    always_comb begin
        w_x     = r_x_a;
        w_integ = r_integ[0];
        w_err   = r_err[0];
        case (r_state)
            ST_B: begin
                w_x     = r_x_b;
                w_integ = r_integ[1];
                w_err   = r_err[1];
            end
            ST_C: begin
                w_x     = r_x_c;
                w_integ = r_integ[2];
                w_err   = r_err[2];
            end
            default: ;
        endcase
    end

    // Input is halved to 0..127 so it can be compared against a signed 8-bit estimate
    assign w_exact    = w_integ + w_err;
    assign w_q        = w_exact[8:1];
    assign w_d        = (w_x >> 1) - w_q;
    assign w_d2       = {w_d, 1'b0};
    assign w_step     = w_d2 >>> K;
    assign w_integ_nx = w_integ + w_step;
    assign w_err_nx   = w_exact - {w_q, 1'b0};

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_x_a   <= '0;
            r_x_b   <= '0;
            r_x_c   <= '0;
            dout_a  <= '0;
            dout_b  <= '0;
            dout_c  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_integ[i] <= '0;
                r_err[i]   <= '0;
            end
        end else begin
            done    <= 1'b0;
            overrun <= cen && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (cen) begin
                        r_x_a   <= din_a;
                        r_x_b   <= din_b;
                        r_x_c   <= din_c;
                        r_state <= ST_A;
                    end
                end
                ST_A: begin
                    dout_a     <= w_d;
                    r_integ[0] <= w_integ_nx;
                    r_err[0]   <= w_err_nx;
                    r_state    <= ST_B;
                end
                ST_B: begin
                    dout_b     <= w_d;
                    r_integ[1] <= w_integ_nx;
                    r_err[1]   <= w_err_nx;
                    r_state    <= ST_C;
                end
                default: begin
                    dout_c     <= w_d;
                    r_integ[2] <= w_integ_nx;
                    r_err[2]   <= w_err_nx;
                    done       <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt49_dcrm_sched.sv
// Directed self-checking bench for jt49_dcrm_sched (K=2); expected values hand-derived.
module tb_jt49_dcrm_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic [7:0] din_a = '0, din_b = '0, din_c = '0;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       done, busy, overrun;

    int n_vec = 0;
    int n_err = 0;

    jt49_dcrm_sched #(.K(2)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .din_a(din_a), .din_b(din_b), .din_c(din_c),
        .dout_a(dout_a), .dout_b(dout_b), .dout_c(dout_c),
        .done(done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cen   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // One accepted strobe; returns one step after the edge that ends state C.
    task automatic run_sample();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        din_a = 8'hFF; din_b = 8'h80; din_c = 8'h11;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cen = ~cen;
            tick();
        end
        rst_n = 1'b1;
        cen   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (dout_a !== 8'd0) begin n_err++; $display("FAIL reset_dout_a: got %0d expected 0", dout_a); end
            n_vec++; if (dout_b !== 8'd0) begin n_err++; $display("FAIL reset_dout_b: got %0d expected 0", dout_b); end
            n_vec++; if (dout_c !== 8'd0) begin n_err++; $display("FAIL reset_dout_c: got %0d expected 0", dout_c); end
            n_vec++; if ({done, busy, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got done/busy/ovr=%b expected 000", {done, busy, overrun}); end
            tick();
        end
    endtask

    task automatic test_arith();
        int exp_a [3] = '{64, 48, 36};
        do_reset();
        din_a = 8'h80; din_b = 8'h00; din_c = 8'h00;
        for (int i = 0; i < 3; i++) begin
            run_sample();
            n_vec++; if (dout_a !== 8'(exp_a[i])) begin n_err++; $display("FAIL arith_dout_a[%0d]: got %0d expected %0d", i, $signed(dout_a), exp_a[i]); end
            n_vec++; if (dout_b !== 8'd0) begin n_err++; $display("FAIL arith_dout_b[%0d]: got %0d expected 0", i, $signed(dout_b)); end
            n_vec++; if (dout_c !== 8'd0) begin n_err++; $display("FAIL arith_dout_c[%0d]: got %0d expected 0", i, $signed(dout_c)); end
            n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL arith_done[%0d]: got %b expected 1", i, done); end
            tick();
        end
    endtask

    // Exercises the error term (channel B) and negative steps after a step down (channel A).
    task automatic test_mixed();
        int exp_a [8] = '{64, 48, 36, 27, 21, -49, -36, -27};
        int exp_b [8] = '{25, 19, 15, 11, 8, 7, 5, 4};
        do_reset();
        din_b = 8'h33; din_c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            din_a = (i < 5) ? 8'h80 : 8'h00;
            run_sample();
            n_vec++; if (dout_a !== 8'(exp_a[i])) begin n_err++; $display("FAIL mixed_dout_a[%0d]: got %0d expected %0d", i, $signed(dout_a), exp_a[i]); end
            n_vec++; if (dout_b !== 8'(exp_b[i])) begin n_err++; $display("FAIL mixed_dout_b[%0d]: got %0d expected %0d", i, $signed(dout_b), exp_b[i]); end
            tick();
        end
    endtask

    task automatic test_sequencing();
        do_reset();
        din_a = 8'h80; din_b = 8'h40; din_c = 8'h20;
        cen = 1'b1;
        tick();
        cen = 1'b0;
        din_a = 8'hFF; din_b = 8'hFF; din_c = 8'hFF;
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL seq_t0_flags: got busy/done=%b expected 10", {busy, done}); end
        n_vec++; if (dout_a !== 8'd0) begin n_err++; $display("FAIL seq_t0_dout_a: got %0d expected 0", dout_a); end
        tick();
        n_vec++; if (dout_a !== 8'd64) begin n_err++; $display("FAIL seq_t1_dout_a: got %0d expected 64", dout_a); end
        n_vec++; if (dout_b !== 8'd0) begin n_err++; $display("FAIL seq_t1_dout_b: got %0d expected 0", dout_b); end
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL seq_t1_flags: got busy/done=%b expected 10", {busy, done}); end
        tick();
        n_vec++; if (dout_b !== 8'd32) begin n_err++; $display("FAIL seq_t2_dout_b: got %0d expected 32", dout_b); end
        n_vec++; if (dout_c !== 8'd0) begin n_err++; $display("FAIL seq_t2_dout_c: got %0d expected 0", dout_c); end
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL seq_t2_flags: got busy/done=%b expected 10", {busy, done}); end
        tick();
        n_vec++; if (dout_c !== 8'd16) begin n_err++; $display("FAIL seq_t3_dout_c: got %0d expected 16", dout_c); end
        n_vec++; if ({busy, done, overrun} !== 3'b010) begin n_err++; $display("FAIL seq_t3_flags: got busy/done/ovr=%b expected 010", {busy, done, overrun}); end
        tick();
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL seq_t4_flags: got busy/done=%b expected 00", {busy, done}); end
    endtask

    task automatic test_overrun();
        do_reset();
        din_a = 8'h80; din_b = 8'h40; din_c = 8'h20;
        cen = 1'b1;
        tick();
        cen = 1'b0;
        tick();
        din_a = 8'hFF; din_b = 8'hFF; din_c = 8'hFF;
        cen = 1'b1;
        tick();
        cen = 1'b0;
        n_vec++; if ({overrun, busy, done} !== 3'b110) begin n_err++; $display("FAIL ovr_t2_flags: got ovr/busy/done=%b expected 110", {overrun, busy, done}); end
        n_vec++; if (dout_b !== 8'd32) begin n_err++; $display("FAIL ovr_t2_dout_b: got %0d expected 32", dout_b); end
        tick();
        n_vec++; if ({overrun, done} !== 2'b01) begin n_err++; $display("FAIL ovr_t3_flags: got ovr/done=%b expected 01", {overrun, done}); end
        n_vec++; if (dout_a !== 8'd64) begin n_err++; $display("FAIL ovr_t3_dout_a: got %0d expected 64", dout_a); end
        n_vec++; if (dout_c !== 8'd16) begin n_err++; $display("FAIL ovr_t3_dout_c: got %0d expected 16", dout_c); end
        din_a = 8'h80; din_b = 8'h40; din_c = 8'h20;
        cen = 1'b1;
        tick();
        cen = 1'b0;
        n_vec++; if ({overrun, busy, done} !== 3'b010) begin n_err++; $display("FAIL ovr_t4_accept: got ovr/busy/done=%b expected 010", {overrun, busy, done}); end
        repeat (3) tick();
        n_vec++; if ({overrun, done} !== 2'b01) begin n_err++; $display("FAIL ovr_t7_flags: got ovr/done=%b expected 01", {overrun, done}); end
        n_vec++; if (dout_a !== 8'd48) begin n_err++; $display("FAIL ovr_2nd_dout_a: got %0d expected 48", dout_a); end
        n_vec++; if (dout_b !== 8'd24) begin n_err++; $display("FAIL ovr_2nd_dout_b: got %0d expected 24", dout_b); end
        n_vec++; if (dout_c !== 8'd12) begin n_err++; $display("FAIL ovr_2nd_dout_c: got %0d expected 12", dout_c); end
    endtask

    task automatic test_convergence();
        int v;
        do_reset();
        din_a = 8'h00; din_b = 8'h00; din_c = 8'hFF;
        for (int i = 0; i < 200; i++) begin
            run_sample();
            v = int'($signed(dout_c));
            if (i == 0) begin
                n_vec++; if (dout_c !== 8'd127) begin n_err++; $display("FAIL conv_first_dout_c: got %0d expected 127", v); end
            end else if (i >= 64) begin
                n_vec++; if (v > 2 || v < -2) begin n_err++; $display("FAIL conv_settled_dout_c[%0d]: got %0d expected |x|<=2", i, v); end
            end
            n_vec++; if ({dout_a, dout_b} !== 16'd0) begin n_err++; $display("FAIL conv_ab_zero[%0d]: got a=%0d b=%0d expected 0 0", i, dout_a, dout_b); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        din_a = 8'h80; din_b = 8'h00; din_c = 8'h00;
        cen = 1'b1;
        tick();
        cen = 1'b0;
        tick();
        n_vec++; if (dout_a !== 8'd64) begin n_err++; $display("FAIL rmid_t1_dout_a: got %0d expected 64", dout_a); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++; if (dout_a !== 8'd0) begin n_err++; $display("FAIL rmid_dout_a_cleared: got %0d expected 0", dout_a); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rmid_no_done[%0d]: got busy/done=%b expected 00", i, {busy, done}); end
            tick();
        end
        run_sample();
        n_vec++; if (dout_a !== 8'd64) begin n_err++; $display("FAIL rmid_restart_dout_a: got %0d expected 64", dout_a); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rmid_restart_done: got %b expected 1", done); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mixed();
        test_sequencing();
        test_overrun();
        test_convergence();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
